usb_in_ep_arbiter: RTL and testbench

USB_IN_EP_ARBITER -- requirements
Module: usb_in_ep_arbiter

---
 rtl/usb_in_ep_arbiter_if.sv | 30 +++
 rtl/usb_in_ep_arbiter.sv | 147 ++++++++++++++
 tb/tb_usb_in_ep_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_in_ep_arbiter_if.sv
// Bundle of requester-side and shared-buffer-side signals for the IN endpoint arbiter.
// The environment drives through "master"; the arbiter connects through "slave".
interface usb_in_ep_arbiter_if #(
  parameter int NUM_EP = 2
);
  logic [NUM_EP-1:0]   ep_req;
  logic [NUM_EP-1:0]   ep_grant;
  logic [NUM_EP-1:0]   ep_data_put;
  logic [8*NUM_EP-1:0] ep_data;
  logic [NUM_EP-1:0]   ep_data_done;
  logic [NUM_EP-1:0]   ep_stall;
  logic [NUM_EP-1:0]   ep_data_free;
  logic [NUM_EP-1:0]   ep_acked;
  logic                buf_data_free;
  logic                buf_data_put;
  logic [7:0]          buf_data;
  logic                buf_data_done;
  logic                buf_stall;
  logic                buf_acked;

  modport master (
    output ep_req, ep_data_put, ep_data, ep_data_done, ep_stall, buf_data_free, buf_acked,
    input  ep_grant, ep_data_free, ep_acked, buf_data_put, buf_data, buf_data_done, buf_stall
  );

  modport slave (
    input  ep_req, ep_data_put, ep_data, ep_data_done, ep_stall, buf_data_free, buf_acked,
    output ep_grant, ep_data_free, ep_acked, buf_data_put, buf_data, buf_data_done, buf_stall
  );
endinterface

// File: rtl/usb_in_ep_arbiter.sv
// Round-robin arbiter letting NUM_EP IN-endpoint requesters share one IN buffer,
// one packet per grant, with byte limit, idle timeout, stall and abort handling.
module usb_in_ep_arbiter #(
  parameter int NUM_EP  = 2,
  parameter int MAX_PKT = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  usb_in_ep_arbiter_if.slave bus,
  output logic [1:0]         owner,
  output logic               busy,
  output logic               overflow
);
  typedef enum logic [1:0] {IDLE, XFER, WAIT_ACK} state_t;

  state_t            state, state_next;
  logic [NUM_EP-1:0] grant, owner_oh, pick_oh, free_out, acked_out;
  logic [1:0]        last_owner, pick;
  logic              pick_valid;
  logic [6:0]        byte_cnt;
  logic [7:0]        idle_cnt;
  logic [7:0]        own_data, data_out;
  logic              own_req, own_put, own_done, own_stall;
  logic              room, room_free, timeout_hit;
  logic              put_out, done_out, stall_out;

  always_comb begin
    owner_oh = '0;
    own_data = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      owner_oh[i] = (owner == 2'(i));
      if (owner == 2'(i)) own_data = bus.ep_data[8*i +: 8];
    end
  end

  assign own_req   = |(bus.ep_req       & owner_oh);
  assign own_put   = |(bus.ep_data_put  & owner_oh);
  assign own_done  = |(bus.ep_data_done & owner_oh);
  assign own_stall = |(bus.ep_stall     & owner_oh);

  assign room        = (byte_cnt < 7'(MAX_PKT));
  assign room_free   = bus.buf_data_free & room;
  assign timeout_hit = !own_put && (idle_cnt == 8'(TIMEOUT - 1));

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    pick_oh    = '0;
    for (int k = 1; k <= NUM_EP; k++) begin
      for (int i = 0; i < NUM_EP; i++) begin
        if (!pick_valid && bus.ep_req[i] && (((int'(last_owner) + k) % NUM_EP) == i)) begin
          pick_valid = 1'b1;
          pick       = 2'(i);
        end
      end
    end
    for (int i = 0; i < NUM_EP; i++) pick_oh[i] = (pick == 2'(i));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Priority when events coincide: stall, then done (or ack), then abort, then timeout.
  always_comb begin
    state_next = state;
    put_out    = 1'b0;
    data_out   = '0;
    done_out   = 1'b0;
    stall_out  = 1'b0;
    free_out   = '0;
    acked_out  = '0;
    case (state)
      IDLE: begin
        if (pick_valid) state_next = XFER;
      end
      XFER: begin
        data_out = own_data;
        free_out = owner_oh & {NUM_EP{room_free}};
        put_out  = own_put & room_free;
        if (own_stall) begin
          stall_out  = 1'b1;
          state_next = IDLE;
        end else if (own_done) begin
          done_out   = 1'b1;
          state_next = WAIT_ACK;
        end else if (!own_req || timeout_hit) begin
          state_next = IDLE;
        end
      end
      WAIT_ACK: begin
        if (own_stall) begin
          stall_out  = 1'b1;
          state_next = IDLE;
        end else if (bus.buf_acked) begin
          acked_out  = owner_oh;
          state_next = IDLE;
        end else if (!own_req) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant      <= '0;
      owner      <= '0;
      last_owner <= 2'(NUM_EP - 1);
      byte_cnt   <= '0;
      idle_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (pick_valid) begin
          owner    <= pick;
          grant    <= pick_oh;
          byte_cnt <= '0;
          idle_cnt <= '0;
        end
      end else begin
        if (state == XFER) begin
          if (put_out) byte_cnt <= byte_cnt + 7'd1;
          if (own_put && !room) overflow <= 1'b1;
          idle_cnt <= own_put ? 8'd0 : idle_cnt + 8'd1;
        end
        if (state_next == IDLE) begin
          grant      <= '0;
          last_owner <= owner;
        end
      end
    end
  end

  assign bus.ep_grant      = grant;
  assign bus.ep_data_free  = free_out;
  assign bus.ep_acked      = acked_out;
  assign bus.buf_data_put  = put_out;
  assign bus.buf_data      = data_out;
  assign bus.buf_data_done = done_out;
  assign bus.buf_stall     = stall_out;
  assign busy              = (state != IDLE);
endmodule

// File: tb/tb_usb_in_ep_arbiter.sv
// Directed bench for usb_in_ep_arbiter: a per-cycle vector table followed by
// hand-written packet, overflow, timeout and mid-transfer reset sequences.
module tb_usb_in_ep_arbiter;
  logic       clk;
  logic       reset_n;
  logic [1:0] owner;
  logic       busy;
  logic       overflow;
  int         tests;
  int         fails;

  usb_in_ep_arbiter_if #(.NUM_EP(2)) bus ();

  usb_in_ep_arbiter #(.NUM_EP(2), .MAX_PKT(32), .TIMEOUT(10)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus.slave),
    .owner    (owner),
    .busy     (busy),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req, put, done, stall;
    logic [15:0] data;
    logic        free, acked_in;
    logic [1:0]  exp_grant, exp_free, exp_acked;
    logic        exp_put;
    logic [7:0]  exp_data;
    logic        exp_done, exp_stall, exp_busy;
    logic [1:0]  exp_owner;
  } vec_t;

  vec_t vecs [15];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    bus.ep_req        = v.req;
    bus.ep_data_put   = v.put;
    bus.ep_data_done  = v.done;
    bus.ep_stall      = v.stall;
    bus.ep_data       = v.data;
    bus.buf_data_free = v.free;
    bus.buf_acked     = v.acked_in;
  endtask

  task automatic idle_inputs();
    bus.ep_req        = '0;
    bus.ep_data_put   = '0;
    bus.ep_data_done  = '0;
    bus.ep_stall      = '0;
    bus.ep_data       = '0;
    bus.buf_data_free = 1'b1;
    bus.buf_acked     = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_grant(input string name, input logic [1:0] expected, input int budget);
    logic found;
    found = 1'b0;
    for (int c = 0; c < budget; c++) begin
      next_cycle();
      if (bus.ep_grant === expected) begin
        found = 1'b1;
        break;
      end
    end
    check_output(name, 32'(found), 32'd1);
  endtask

  task automatic put_bytes(input int count, output int forwarded, output int bad_data);
    forwarded = 0;
    bad_data  = 0;
    for (int b = 0; b < count; b++) begin
      bus.ep_data_put = 2'b01;
      bus.ep_data     = {8'h00, 8'(b)};
      #1;
      if (bus.buf_data_put === 1'b1) begin
        forwarded++;
        if (bus.buf_data !== 8'(b)) bad_data++;
      end
      next_cycle();
    end
    bus.ep_data_put = '0;
  endtask

  initial begin
    int fwd, bad, done_cnt;
    tests = 0;
    fails = 0;

    vecs[0]  = '{2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{2'b11, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[2]  = '{2'b11, 2'b01, 2'b00, 2'b00, 16'h3CA5, 1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 2'd0};
    vecs[3]  = '{2'b11, 2'b10, 2'b00, 2'b00, 16'h3CA5, 1'b1, 1'b1, 2'b01, 2'b01, 2'b00, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 2'd0};
    vecs[4]  = '{2'b11, 2'b01, 2'b00, 2'b00, 16'h3CA5, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 2'd0};
    vecs[5]  = '{2'b11, 2'b01, 2'b01, 2'b00, 16'h3C5A, 1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 2'd0};
    vecs[6]  = '{2'b11, 2'b00, 2'b00, 2'b00, 16'h3C5A, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0};
    vecs[7]  = '{2'b11, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b1, 2'b01, 2'b00, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0};
    vecs[8]  = '{2'b11, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[9]  = '{2'b11, 2'b11, 2'b00, 2'b00, 16'h2211, 1'b1, 1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[10] = '{2'b01, 2'b10, 2'b00, 2'b00, 16'h3311, 1'b1, 1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[11] = '{2'b01, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[12] = '{2'b01, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0};
    vecs[13] = '{2'b01, 2'b00, 2'b01, 2'b01, 16'h0000, 1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd0};
    vecs[14] = '{2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0};

    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    check_output("reset_grant", 32'(bus.ep_grant), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_owner", 32'(owner), 32'd0);
    check_output("reset_overflow", 32'(overflow), 32'd0);
    reset_n = 1'b1;

    // One vector per clock: drive after the falling edge, compare just after.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("v%0d_grant", i), 32'(bus.ep_grant), 32'(vecs[i].exp_grant));
      check_output($sformatf("v%0d_free", i), 32'(bus.ep_data_free), 32'(vecs[i].exp_free));
      check_output($sformatf("v%0d_acked", i), 32'(bus.ep_acked), 32'(vecs[i].exp_acked));
      check_output($sformatf("v%0d_put", i), 32'(bus.buf_data_put), 32'(vecs[i].exp_put));
      check_output($sformatf("v%0d_data", i), 32'(bus.buf_data), 32'(vecs[i].exp_data));
      check_output($sformatf("v%0d_done", i), 32'(bus.buf_data_done), 32'(vecs[i].exp_done));
      check_output($sformatf("v%0d_stall", i), 32'(bus.buf_stall), 32'(vecs[i].exp_stall));
      check_output($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      if (vecs[i].exp_busy) check_output($sformatf("v%0d_owner", i), 32'(owner), 32'(vecs[i].exp_owner));
    end

    // 18-byte packet, done, then host ack.
    do_reset();
    bus.ep_req = 2'b01;
    wait_grant("pkt_grant", 2'b01, 5);
    put_bytes(18, fwd, bad);
    check_output("pkt_put_count", 32'(fwd), 32'd18);
    check_output("pkt_data_errors", 32'(bad), 32'd0);
    bus.ep_data_done = 2'b01;
    #1;
    done_cnt = (bus.buf_data_done === 1'b1) ? 1 : 0;
    next_cycle();
    bus.ep_data_done = '0;
    #1;
    if (bus.buf_data_done === 1'b1) done_cnt++;
    check_output("pkt_done_pulses", 32'(done_cnt), 32'd1);
    check_output("pkt_wait_busy", 32'(busy), 32'd1);
    check_output("pkt_no_early_ack", 32'(bus.ep_acked), 32'd0);
    next_cycle();
    bus.buf_acked = 1'b1;
    #1;
    check_output("pkt_acked", 32'(bus.ep_acked), 32'd1);
    next_cycle();
    bus.buf_acked = 1'b0;
    #1;
    check_output("pkt_acked_end", 32'(bus.ep_acked), 32'd0);
    check_output("pkt_busy_fall", 32'(busy), 32'd0);

    // 33 bytes against a 32-byte limit.
    do_reset();
    bus.ep_req = 2'b01;
    wait_grant("ovf_grant", 2'b01, 5);
    put_bytes(32, fwd, bad);
    check_output("ovf_first32", 32'(fwd), 32'd32);
    check_output("ovf_first32_data", 32'(bad), 32'd0);
    check_output("ovf_not_yet", 32'(overflow), 32'd0);
    check_output("ovf_free_closed", 32'(bus.ep_data_free), 32'd0);
    put_bytes(1, fwd, bad);
    check_output("ovf_33rd_dropped", 32'(fwd), 32'd0);
    check_output("ovf_set", 32'(overflow), 32'd1);
    bus.ep_data_done = 2'b01;
    next_cycle();
    bus.ep_data_done = '0;
    bus.buf_acked    = 1'b1;
    next_cycle();
    bus.buf_acked = 1'b0;
    repeat (3) next_cycle();
    check_output("ovf_sticky", 32'(overflow), 32'd1);
    do_reset();
    check_output("ovf_cleared", 32'(overflow), 32'd0);

    // Owner holds the grant without putting: revoked after 10 idle cycles.
    bus.ep_req = 2'b11;
    wait_grant("tmo_grant", 2'b01, 5);
    done_cnt = 0;
    for (int c = 0; c < 9; c++) begin
      next_cycle();
      if (bus.buf_data_done === 1'b1) done_cnt++;
    end
    check_output("tmo_still_granted", 32'(bus.ep_grant), 32'd1);
    next_cycle();
    check_output("tmo_revoked", 32'(bus.ep_grant), 32'd0);
    check_output("tmo_busy", 32'(busy), 32'd0);
    check_output("tmo_no_done", 32'(done_cnt), 32'd0);
    next_cycle();
    check_output("tmo_next_owner", 32'(bus.ep_grant), 32'd2);

    // Reset dropped in the middle of a packet.
    do_reset();
    bus.ep_req = 2'b01;
    wait_grant("rst_grant", 2'b01, 5);
    put_bytes(5, fwd, bad);
    check_output("rst_five_bytes", 32'(fwd), 32'd5);
    bus.buf_acked = 1'b1;
    reset_n       = 1'b0;
    #1;
    check_output("rst_grant_drop", 32'(bus.ep_grant), 32'd0);
    check_output("rst_busy_drop", 32'(busy), 32'd0);
    check_output("rst_no_ack", 32'(bus.ep_acked), 32'd0);
    check_output("rst_no_done", 32'(bus.buf_data_done), 32'd0);
    repeat (2) @(negedge clk);
    reset_n       = 1'b1;
    bus.buf_acked = 1'b0;
    bus.ep_req    = 2'b11;
    next_cycle();
    check_output("rst_req0_wins", 32'(bus.ep_grant), 32'd1);
    check_output("rst_owner0", 32'(owner), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end
endmodule
